// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen -- program-counter generator for the fetch stage.
//
// Drives the instruction memory address, read enable and flush inputs. It also
// tracks the PC of the instruction on the memory's registered output and
// flags whether that instruction is valid.
//
// Ports:
//   clk                system clock; all state updates on the rising edge
//   rst                asynchronous, active-low reset
//   stall_i            hazard unit: hold fetch this cycle
//   redirect_valid_i   execute: taken branch/jump this cycle
//   redirect_target_i  execute: new fetch address
//   imem_pc_o          fetch address to instruction memory (equals pc_q)
//   imem_read_en_o     instruction memory read enable
//   imem_flush_o       instruction memory flush (forces a NOP into its output)
//   if_pc_o            PC of the instruction currently on the memory output
//   if_valid_o         memory output holds a valid, non-flushed instruction
//   misalign_exc_o     one-cycle pulse: redirect target not word-aligned
//   misalign_addr_o    offending target, held until the next exception
module fetch_pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] imem_pc_o,
    output logic        imem_read_en_o,
    output logic        imem_flush_o,
    output logic [31:0] if_pc_o,
    output logic        if_valid_o,
    output logic        misalign_exc_o,
    output logic [31:0] misalign_addr_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        exc_q, exc_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic        read_en, flush;
    logic        target_aligned;

    assign target_aligned = (redirect_target_i[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            exc_q      <= exc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Reset forces the state to BOOT immediately, so the BOOT decode also
    // gives read_en=0 / flush=1 for the whole time rst is held low.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        exc_d      = 1'b0;
        exc_addr_d = exc_addr_q;
        read_en    = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            BOOT: begin
                flush   = 1'b1;
                state_d = RUN;
            end

            RUN: begin
                if (redirect_valid_i) begin
                    // Redirect outranks stall; the in-flight slot is flushed.
                    flush      = 1'b1;
                    if_valid_d = 1'b0;
                    if (target_aligned) begin
                        pc_d = redirect_target_i;
                    end else begin
                        exc_d      = 1'b1;
                        exc_addr_d = redirect_target_i;
                        state_d    = HALT;
                    end
                end else if (!stall_i) begin
                    read_en    = 1'b1;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end

            HALT: begin
                flush      = 1'b1;
                if_valid_d = 1'b0;
                if (redirect_valid_i) begin
                    if (target_aligned) begin
                        pc_d    = redirect_target_i;
                        state_d = RUN;
                    end else begin
                        exc_d      = 1'b1;
                        exc_addr_d = redirect_target_i;
                    end
                end
            end

            default: begin
                flush   = 1'b1;
                state_d = BOOT;
            end
        endcase
    end

    assign imem_pc_o       = pc_q;
    assign imem_read_en_o  = read_en;
    assign imem_flush_o    = flush;
    assign if_pc_o         = if_pc_q;
    assign if_valid_o      = if_valid_q;
    assign misalign_exc_o  = exc_q;
    assign misalign_addr_o = exc_addr_q;

endmodule
